// File: rtl/alu_pkg.sv
// Shared opcode and FSM definitions for the bit-serial ALU sequencer and its slice.
package alu_pkg;

  localparam logic [2:0] CMD_ADD  = 3'b000;
  localparam logic [2:0] CMD_SUB  = 3'b001;
  localparam logic [2:0] CMD_XOR  = 3'b010;
  localparam logic [2:0] CMD_SLT  = 3'b011;
  localparam logic [2:0] CMD_AND  = 3'b100;
  localparam logic [2:0] CMD_NAND = 3'b101;
  localparam logic [2:0] CMD_NOR  = 3'b110;
  localparam logic [2:0] CMD_OR   = 3'b111;

  localparam logic [2:0] CMD_SLICE_ADD = 3'b000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_bit_counter.sv
// Loadable bit-index counter; flags the final bit so the sequencer knows when to stop.
module serial_bit_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     load_i,
  input  logic                     inc_i,
  output logic [$clog2(WIDTH)-1:0] idx_o,
  output logic                     last_o
);

  localparam int unsigned IW = $clog2(WIDTH);

  logic [IW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || load_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign idx_o  = cnt_q;
  assign last_o = (cnt_q == IW'(WIDTH - 1));

endmodule

// File: rtl/bit_serial_alu_sequencer.sv
// Drives an external single-bit ALU slice LSB first and assembles the WIDTH-bit result.
import alu_pkg::*;

module bit_serial_alu_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic [2:0]       command,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             zero,
  output logic             overflow,
  output logic             sliceA,
  output logic             sliceB,
  output logic             slicecarryin,
  output logic [2:0]       slicecommand,
  input  logic             sliceresult,
  input  logic             slicecarryout
);

  localparam int unsigned IW = $clog2(WIDTH);

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [2:0]       cmd_q;
  logic             carry_q, carryout_q, overflow_q, done_q;
  logic [IW-1:0]    idx;
  logic             last;
  logic             accept, in_run, invert_b, arith, last_ovf;

  assign in_run   = (state_q == RUN);
  assign accept   = start && (state_q == IDLE || state_q == DONE);
  assign invert_b = (cmd_q == CMD_SUB) || (cmd_q == CMD_SLT);
  assign arith    = (cmd_q == CMD_ADD) || invert_b;
  assign last_ovf = carry_q ^ slicecarryout;

  serial_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk_i  (clk),
    .rst_i  (reset),
    .load_i (accept),
    .inc_i  (in_run && !last),
    .idx_o  (idx),
    .last_o (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      cmd_q      <= CMD_ADD;
      carry_q    <= 1'b0;
      result_q   <= '0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q        <= operandA;
            b_q        <= operandB;
            cmd_q      <= command;
            carry_q    <= (command == CMD_SUB) || (command == CMD_SLT);
            result_q   <= '0;
            carryout_q <= 1'b0;
            overflow_q <= 1'b0;
            state_q    <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          result_q[idx] <= sliceresult;
          carry_q       <= slicecarryout;
          if (last) begin
            state_q    <= DONE;
            done_q     <= 1'b1;
            overflow_q <= arith && last_ovf;
            carryout_q <= arith && (cmd_q != CMD_SLT) && slicecarryout;
            // SLT replaces the whole difference with its sign-corrected MSB
            if (cmd_q == CMD_SLT) begin
              result_q <= WIDTH'(sliceresult ^ last_ovf);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = in_run;
  assign done     = done_q;
  assign result   = result_q;
  assign carryout = carryout_q;
  assign overflow = overflow_q;
  assign zero     = (state_q == DONE) && (result_q == '0);

  assign sliceA       = in_run && a_q[idx];
  assign sliceB       = in_run && (b_q[idx] ^ invert_b);
  assign slicecarryin = in_run && carry_q;
  assign slicecommand = (in_run && !arith) ? cmd_q : CMD_SLICE_ADD;

endmodule
